alu_4bit: RTL and testbench
===========================

# alu_4bit

Registered 4-bit arithmetic/logic unit: add, subtract, bitwise AND, and bitwise OR on two unsigned operands. It also produces an unsigned carry/borrow overflow flag. It is the datapath execution stage of the small example processor. Operands are sampled on a clock edge, and the result is presented one cycle later with a valid strobe.

## Interface
- Clocking: one clock; reset is asynchronous and active-low.
- Parameters: none. Data width is fixed at 4 bits.
- Opcode constants, 2-bit, exported from the package shared with the testbench:
  - ADD = 2'b00
  - SUB = 2'b01
  - AND = 2'b10
  - OR = 2'b11
- Ports:
  - clk  input  1  rising-edge clock
  - rst_n  input  1  asynchronous active-low reset
  - in_valid  input  1  operands and opcode are valid this cycle
  - a  input  4  first operand (unsigned)
  - b  input  4  second operand (unsigned)
  - op  input  2  operation select (ADD/SUB/AND/OR)
  - result  output  4  registered operation result
  - overflow  output  1  registered unsigned carry/borrow flag
  - out_valid  output  1  result/overflow updated by the previous cycle's in_valid

## Operation
- ADD:
  - {carry, sum} = a + b, computed 5 bits wide.
  - result = sum[3:0]; overflow = carry (bit 4).
- SUB:
  - result = (a − b) mod 16.
  - overflow = 1 when a < b (unsigned borrow), else 0.
  - Signed two's-complement overflow is not reported.
- AND: result = a & b; overflow = 0.
- OR: result = a | b; overflow = 0.
- Only in_valid gates capture. All four opcodes are legal; no illegal-op state exists.
- The design is purely datapath plus one register stage. There is no state machine and no backpressure; a new operation may be issued every cycle.

## Timing
- Reset (rst_n low, asynchronous assert):
  - result = 4'b0000, overflow = 0, out_valid = 0 immediately.
  - Outputs stay at these values while rst_n is low.
- Reset release is synchronous to clk. The first capture can happen at the first rising edge after rst_n goes high.
- Edge with in_valid = 1: result and overflow load the computed values; out_valid = 1. Latency is exactly 1 cycle.
- Edge with in_valid = 0: result and overflow hold their previous values; out_valid = 0.
- Back-to-back operations give back-to-back out_valid pulses, one result per cycle, in issue order.
- Reset asserted mid-stream: any operation captured but not yet consumed is discarded. Outputs return to reset values, and no out_valid is produced for it.
- Inputs need only be stable around the rising edge. Outputs change only on clk or rst_n.

## Test plan
- ADD, no overflow: a=0100, b=0011, in_valid=1 -> next cycle result=0111, overflow=0, out_valid=1.
- SUB: a=1010, b=0100 -> result=0110, overflow=0.
  - Must not flag signed overflow.
- AND and OR:
  - a=1010, b=1100, op=AND -> result=1000, overflow=0.
  - Same operands, op=OR -> result=1110, overflow=0.
  - Issue the two operations on consecutive cycles; expect two consecutive out_valid pulses.
- Wrap-around:
  - ADD 1111+0001 -> result=0000, overflow=1.
  - SUB 0000−0001 -> result=1111, overflow=1.
  - SUB 0101−0101 -> result=0000, overflow=0.
- Hold and reset:
  - Drop in_valid for 3 cycles -> out_valid=0, result/overflow unchanged.
  - Assert rst_n=0 between clock edges -> outputs 0 immediately, with no result emitted for the operation in flight.
- Exhaustive: all 256 (a, b) pairs × 4 ops, compared against a reference model one cycle after issue.

Source files
------------

// File: rtl/alu_4bit_if.sv
// Operand/result bundle for the 4-bit execute stage.
// The master issues operations; the slave returns registered results.
interface alu_4bit_if;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] op;
  logic [3:0] result;
  logic       overflow;
  logic       out_valid;

  modport master (
    output in_valid,
    output a,
    output b,
    output op,
    input  result,
    input  overflow,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  op,
    output result,
    output overflow,
    output out_valid
  );
endinterface

// File: rtl/alu_4bit.sv
// Registered 4-bit ALU execute stage: add, sub, and, or.
// One-cycle latency, no backpressure, unsigned carry/borrow flag.
package alu_4bit_pkg;
  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] AND = 2'b10;
  localparam logic [1:0] OR  = 2'b11;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
  } ex_req_t;

  typedef struct packed {
    logic [3:0] result;
    logic       overflow;
  } ex_rsp_t;
endpackage

module alu_4bit
  import alu_4bit_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  alu_4bit_if.slave bus
);

  ex_req_t    req;
  ex_rsp_t    rsp_d;
  ex_rsp_t    rsp_q;
  logic       valid_q;
  logic [4:0] sum;
  logic [4:0] diff;

  assign req.a  = bus.a;
  assign req.b  = bus.b;
  assign req.op = bus.op;

  // Bit 4 of the widened difference is the unsigned borrow (a < b).
  assign sum  = {1'b0, req.a} + {1'b0, req.b};
  assign diff = {1'b0, req.a} - {1'b0, req.b};

  always_comb begin
    rsp_d = '0;
    unique case (1'b1)
      (req.op == ADD): begin
        rsp_d.result   = sum[3:0];
        rsp_d.overflow = sum[4];
      end
      (req.op == SUB): begin
        rsp_d.result   = diff[3:0];
        rsp_d.overflow = diff[4];
      end
      (req.op == AND): begin
        rsp_d.result   = req.a & req.b;
        rsp_d.overflow = 1'b0;
      end
      (req.op == OR): begin
        rsp_d.result   = req.a | req.b;
        rsp_d.overflow = 1'b0;
      end
      default: rsp_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) rsp_q <= rsp_d;
    end
  end

  assign bus.result    = rsp_q.result;
  assign bus.overflow  = rsp_q.overflow;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_alu_4bit.sv
// Scoreboard bench for the registered 4-bit ALU stage.
// Expectations come from an integer reference model.
module tb_alu_4bit;
  import alu_4bit_pkg::*;

  typedef struct packed {
    logic [3:0] r;
    logic       o;
  } exp_t;

  logic clk;
  logic rst_n;
  alu_4bit_if bus ();

  alu_4bit u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t sb[$];
  exp_t cur;
  logic [3:0] last_r;
  logic       last_o;
  int vectors;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input int a, input int b, input logic [1:0] op);
    exp_t e;
    int   t;
    e = '0;
    case (op)
      2'b00: begin
        t = a + b;
        e.r = 4'(t % 16);
        e.o = (t > 15);
      end
      2'b01: begin
        t = a - b;
        e.r = 4'((t + 16) % 16);
        e.o = (a < b);
      end
      2'b10: e.r = 4'(a) & 4'(b);
      default: e.r = 4'(a) | 4'(b);
    endcase
    return e;
  endfunction

  task automatic drive(input logic v, input int a, input int b, input logic [1:0] op);
    bus.in_valid = v;
    bus.a  = 4'(a);
    bus.b  = 4'(b);
    bus.op = op;
    if (v) sb.push_back(model(a, b, op));
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b0, 0, 0, ADD);
    @(posedge clk); #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.result !== 4'h0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: got v=%b r=%h o=%b want v=0 r=0 o=0",
               bus.out_valid, bus.result, bus.overflow);
    end
    rst_n = 1'b1;
    last_r = 4'h0;
    last_o = 1'b0;
  endtask

  task automatic test_directed;
    int va[7] = '{4, 10, 10, 10, 15, 0, 5};
    int vb[7] = '{3, 4, 12, 12, 1, 1, 5};
    logic [1:0] vo[7] = '{ADD, SUB, AND, OR, ADD, SUB, SUB};
    logic [3:0] wr[7] = '{4'b0111, 4'b0110, 4'b1000, 4'b1110,
                          4'b0000, 4'b1111, 4'b0000};
    logic wo[7] = '{0, 0, 0, 0, 1, 1, 0};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, va[i], vb[i], vo[i]);
      @(posedge clk); #1;
      vectors++;
      cur = sb.size() > 0 ? sb.pop_front() : '0;
      if (bus.out_valid !== 1'b1 || bus.result !== wr[i] || bus.overflow !== wo[i]
          || cur.r !== wr[i] || cur.o !== wo[i]) begin
        errors++;
        $display("FAIL directed[%0d]: got v=%b r=%b o=%b want v=1 r=%b o=%b",
                 i, bus.out_valid, bus.result, bus.overflow, wr[i], wo[i]);
      end
      last_r = wr[i];
      last_o = wo[i];
    end
  endtask

  task automatic test_hold;
    drive(1'b0, 9, 3, OR);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.result !== last_r || bus.overflow !== last_o) begin
        errors++;
        $display("FAIL hold[%0d]: got v=%b r=%b o=%b want v=0 r=%b o=%b",
                 i, bus.out_valid, bus.result, bus.overflow, last_r, last_o);
      end
      bus.a = 4'(i * 5);
      bus.op = 2'(i);
    end
  endtask

  task automatic test_reset_midstream;
    drive(1'b1, 15, 15, ADD);
    @(posedge clk); #1;
    vectors++;
    cur = sb.size() > 0 ? sb.pop_front() : '0;
    if (bus.out_valid !== 1'b1 || bus.result !== cur.r || bus.overflow !== cur.o) begin
      errors++;
      $display("FAIL pre_reset: got v=%b r=%b o=%b want v=1 r=%b o=%b",
               bus.out_valid, bus.result, bus.overflow, cur.r, cur.o);
    end
    drive(1'b1, 0, 1, SUB);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.result !== 4'h0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b r=%b o=%b want v=0 r=0 o=0",
               bus.out_valid, bus.result, bus.overflow);
    end
    sb.delete();
    @(posedge clk); #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.result !== 4'h0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got v=%b r=%b o=%b want v=0 r=0 o=0",
               bus.out_valid, bus.result, bus.overflow);
    end
    drive(1'b0, 0, 0, ADD);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.result !== 4'h0) begin
      errors++;
      $display("FAIL post_reset: got v=%b r=%b want v=0 r=0",
               bus.out_valid, bus.result);
    end
  endtask

  task automatic test_exhaustive;
    for (int o = 0; o < 4; o++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          drive(1'b1, a, b, 2'(o));
          @(posedge clk); #1;
          vectors++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL exh_empty: op=%0d a=%0d b=%0d no expectation", o, a, b);
          end else begin
            cur = sb.pop_front();
            if (bus.out_valid !== 1'b1 || bus.result !== cur.r || bus.overflow !== cur.o) begin
              errors++;
              $display("FAIL exh op=%0d a=%0d b=%0d: got v=%b r=%b o=%b want v=1 r=%b o=%b",
                       o, a, b, bus.out_valid, bus.result, bus.overflow, cur.r, cur.o);
            end
          end
        end
      end
    end
    drive(1'b0, 0, 0, ADD);
    @(posedge clk); #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got v=%b left=%0d want v=0 left=0",
               bus.out_valid, sb.size());
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    bus.in_valid = 1'b0;
    bus.a  = 4'h0;
    bus.b  = 4'h0;
    bus.op = ADD;
    test_reset();
    test_directed();
    test_hold();
    test_reset_midstream();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
